i2c_byte_ctrl: RTL

//  Byte-level I2C master sequencer; sits directly downstream of the SCL divider and consumes its timing strobes.

---
 rtl/i2c_byte_ctrl.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: turns START / write / read / STOP host commands
// into SDA drive and SCL enable/hold, paced by the SCL generator's strobes.
module i2c_byte_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       cmd_nack,
    input  logic [7:0] tx_data,
    input  logic       scl_negedge,
    input  logic       stop_en,
    input  logic       sda_i,
    output logic       scl_en,
    output logic       scl_hold,
    output logic       sda_oe,
    output logic       done,
    output logic       cmd_err,
    output logic [7:0] rx_data,
    output logic       rx_ack
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_ACK    = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_RSTART = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    logic [2:0]             state_q,     state_d;
    logic                   scl_en_q,    scl_en_d;
    logic                   scl_hold_q,  scl_hold_d;
    logic                   sda_oe_q,    sda_oe_d;
    logic                   done_q,      done_d;
    logic                   cmd_err_q,   cmd_err_d;
    logic [7:0]             rx_data_q,   rx_data_d;
    logic                   rx_ack_q,    rx_ack_d;
    logic [2:0]             bit_cnt_q,   bit_cnt_d;
    logic [7:0]             shift_q,     shift_d;
    logic                   lat_start_q, lat_start_d;
    logic                   lat_write_q, lat_write_d;
    logic                   lat_read_q,  lat_read_d;
    logic                   lat_stop_q,  lat_stop_d;
    logic                   lat_nack_q,  lat_nack_d;
    logic                   pending_q,   pending_d;
    logic                   stop_seen_q, stop_seen_d;
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;

    logic       sda_sync;
    logic       accept;
    logic       illegal;
    logic [7:0] shift_smp;
    logic       go_data;
    logic       go_stop;
    logic       go_hold;

    assign sda_sync  = sync_q[SYNC_STAGES-1];
    assign cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && !pending_q);
    assign accept    = cmd_valid && cmd_ready;
    // From IDLE the bus is not owned yet, so anything without a START is rejected.
    assign illegal   = (cmd_write && cmd_read)
                    || !(cmd_start || cmd_write || cmd_read || cmd_stop)
                    || ((state_q == ST_IDLE) && !cmd_start);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        scl_en_d    = scl_en_q;
        scl_hold_d  = scl_hold_q;
        sda_oe_d    = sda_oe_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_ack_d    = rx_ack_q;
        bit_cnt_d   = bit_cnt_q;
        lat_start_d = lat_start_q;
        lat_write_d = lat_write_q;
        lat_read_d  = lat_read_q;
        lat_stop_d  = lat_stop_q;
        lat_nack_d  = lat_nack_q;
        pending_d   = pending_q;
        stop_seen_d = stop_seen_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], sda_i};
        go_data     = 1'b0;
        go_stop     = 1'b0;
        go_hold     = 1'b0;

        // Read sampling on stop_en is folded in first so a coincident scl_negedge sees the new bit.
        shift_smp = shift_q;
        if ((state_q == ST_DATA) && lat_read_q && stop_en) begin
            shift_smp = {shift_q[6:0], sda_sync};
        end
        shift_d = shift_smp;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        done_d    = 1'b1;
                        cmd_err_d = 1'b1;
                    end else begin
                        lat_start_d = cmd_start;
                        lat_write_d = cmd_write;
                        lat_read_d  = cmd_read;
                        lat_stop_d  = cmd_stop;
                        lat_nack_d  = cmd_nack;
                        shift_d     = tx_data;
                        scl_en_d    = 1'b1;
                        sda_oe_d    = 1'b0;
                        state_d     = ST_START;
                    end
                end
            end

            ST_START, ST_RSTART: begin
                if (stop_en) begin
                    sda_oe_d = 1'b1;
                end
                if (scl_negedge) begin
                    if (lat_write_q || lat_read_q) begin
                        go_data = 1'b1;
                    end else if (lat_stop_q) begin
                        go_stop = 1'b1;
                    end else begin
                        go_hold = 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (scl_negedge) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_ACK;
                        if (lat_write_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            sda_oe_d  = !lat_nack_q;
                            rx_data_d = shift_smp;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        if (lat_write_q) begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = !shift_q[6];
                        end
                    end
                end
            end

            ST_ACK: begin
                if (stop_en && lat_write_q) begin
                    rx_ack_d = sda_sync;
                end
                if (scl_negedge) begin
                    if (lat_stop_q) begin
                        go_stop = 1'b1;
                    end else begin
                        go_hold = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                sda_oe_d = 1'b0;
                if (accept) begin
                    if (illegal) begin
                        done_d    = 1'b1;
                        cmd_err_d = 1'b1;
                    end else begin
                        lat_start_d = cmd_start;
                        lat_write_d = cmd_write;
                        lat_read_d  = cmd_read;
                        lat_stop_d  = cmd_stop;
                        lat_nack_d  = cmd_nack;
                        shift_d     = tx_data;
                        pending_d   = 1'b1;
                    end
                end
                // The command waits for a period boundary so SCL is released cleanly.
                if (pending_q && scl_negedge) begin
                    pending_d  = 1'b0;
                    scl_hold_d = 1'b0;
                    if (lat_start_q) begin
                        state_d = ST_RSTART;
                    end else if (lat_write_q || lat_read_q) begin
                        go_data = 1'b1;
                    end else begin
                        go_stop = 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (stop_seen_q) begin
                    stop_seen_d = 1'b0;
                    done_d      = 1'b1;
                    scl_en_d    = 1'b0;
                    scl_hold_d  = 1'b0;
                    state_d     = ST_IDLE;
                end else if (stop_en) begin
                    sda_oe_d    = 1'b0;
                    stop_seen_d = 1'b1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                scl_en_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase

        if (go_data) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd7;
            sda_oe_d  = lat_write_q && !shift_q[7];
        end
        if (go_stop) begin
            state_d  = ST_STOP;
            sda_oe_d = 1'b1;
        end
        if (go_hold) begin
            state_d    = ST_HOLD;
            scl_hold_d = 1'b1;
            sda_oe_d   = 1'b0;
            done_d     = 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            scl_en_q    <= 1'b0;
            scl_hold_q  <= 1'b0;
            sda_oe_q    <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_ack_q    <= 1'b1;
            bit_cnt_q   <= 3'd7;
            shift_q     <= 8'h00;
            lat_start_q <= 1'b0;
            lat_write_q <= 1'b0;
            lat_read_q  <= 1'b0;
            lat_stop_q  <= 1'b0;
            lat_nack_q  <= 1'b0;
            pending_q   <= 1'b0;
            stop_seen_q <= 1'b0;
            sync_q      <= '1;
        end else begin
            state_q     <= state_d;
            scl_en_q    <= scl_en_d;
            scl_hold_q  <= scl_hold_d;
            sda_oe_q    <= sda_oe_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
            rx_data_q   <= rx_data_d;
            rx_ack_q    <= rx_ack_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            lat_start_q <= lat_start_d;
            lat_write_q <= lat_write_d;
            lat_read_q  <= lat_read_d;
            lat_stop_q  <= lat_stop_d;
            lat_nack_q  <= lat_nack_d;
            pending_q   <= pending_d;
            stop_seen_q <= stop_seen_d;
            sync_q      <= sync_d;
        end
    end

    assign scl_en   = scl_en_q;
    assign scl_hold = scl_hold_q;
    assign sda_oe   = sda_oe_q;
    assign done     = done_q;
    assign cmd_err  = cmd_err_q;
    assign rx_data  = rx_data_q;
    assign rx_ack   = rx_ack_q;

endmodule
